ebi_master: RTL and testbench

EBI_MASTER -- requirements
Module: ebi_master

---
 rtl/ebi_master.sv | 222 ++++++++++++++++++++++
 tb/tb_ebi_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ebi_master.sv
// rtl/ebi_master.sv - external bus interface master: one read/write per request with setup/strobe/hold timing
// Optional EBI_MASTER_TA_EN: synchronized ta_n extends the strobe, bounded by TIMEOUT strobe cycles.
module ebi_master #(
    parameter int SETUP_CYCLES = 1,
    parameter int WAIT_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [21:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        cs_n,
    output logic        oe_n,
    output logic [3:0]  we_n,
    output logic        rd_wr,
    output logic [23:0] ebi_addr,
    output logic [31:0] data_o,
    output logic        data_oe,
    input  logic [31:0] data_i,
    input  logic        ta_n
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [21:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        nop_q, nop_d;
    logic [31:0] rdata_q, rdata_d;
    logic        accept;
    logic        bus_d, strobe_d;

    logic        cs_n_q, oe_n_q, rd_wr_q, data_oe_q, busy_q, ack_q;
    logic [3:0]  we_n_q;
    logic [23:0] ebi_addr_q;
    logic [31:0] data_o_q;

`ifdef EBI_MASTER_TA_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    logic       ta_s1_q, ta_s2_q;
    logic [7:0] tcnt_q, tcnt_d;
    logic       terr_q, terr_d;
    logic       err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ta_n | (TIMEOUT > 255);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        nop_d   = nop_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
`ifdef EBI_MASTER_TA_EN
        tcnt_d  = tcnt_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            IDLE: accept = req_i;
            SETUP: begin
                // A write with no byte enables skips the bus entirely.
                if (nop_q) begin
                    state_d = DONE;
                end else if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = WAIT_LD;
`ifdef EBI_MASTER_TA_EN
                    tcnt_d  = 8'd1;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
`ifdef EBI_MASTER_TA_EN
                    tcnt_d = tcnt_q + 8'd1;
`endif
                end
`ifdef EBI_MASTER_TA_EN
                else if (!ta_s2_q) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    if (!wr_q) rdata_d = data_i;
                end else if (tcnt_q >= TO_LIM) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    terr_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
`else
                else begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    if (!wr_q) rdata_d = data_i;
                end
`endif
            end
            HOLD: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DONE: begin
                state_d = IDLE;
                accept  = req_i;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
            wr_d    = wr_i;
            addr_d  = addr_i;
            be_d    = be_i;
            wdata_d = wdata_i;
            nop_d   = wr_i && (be_i == 4'h0);
`ifdef EBI_MASTER_TA_EN
            terr_d  = 1'b0;
`endif
        end
    end

    // Bus pins are registered from next-state values so they change on the same edge as the phase.
    assign bus_d    = (state_d == SETUP || state_d == STROBE || state_d == HOLD) && !nop_d;
    assign strobe_d = bus_d && (state_d == STROBE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= 22'd0;
            be_q       <= 4'h0;
            wdata_q    <= 32'd0;
            nop_q      <= 1'b0;
            rdata_q    <= 32'd0;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 4'hF;
            rd_wr_q    <= 1'b1;
            data_oe_q  <= 1'b0;
            ebi_addr_q <= 24'd0;
            data_o_q   <= 32'd0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            nop_q      <= nop_d;
            rdata_q    <= rdata_d;
            cs_n_q     <= ~bus_d;
            oe_n_q     <= ~(strobe_d && !wr_d);
            we_n_q     <= (strobe_d && wr_d) ? ~be_d : 4'hF;
            rd_wr_q    <= bus_d ? ~wr_d : 1'b1;
            data_oe_q  <= bus_d && wr_d;
            ebi_addr_q <= {addr_d, 2'b00};
            data_o_q   <= (bus_d && wr_d) ? wdata_d : 32'd0;
            busy_q     <= (state_d == SETUP || state_d == STROBE || state_d == HOLD);
            ack_q      <= (state_d == DONE);
        end
    end

`ifdef EBI_MASTER_TA_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ta_s1_q <= 1'b1;
            ta_s2_q <= 1'b1;
            tcnt_q  <= 8'd0;
            terr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ta_s1_q <= ta_n;
            ta_s2_q <= ta_s1_q;
            tcnt_q  <= tcnt_d;
            terr_q  <= terr_d;
            err_q   <= (state_d == DONE) && terr_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o   = busy_q;
    assign ack_o    = ack_q;
    assign rdata_o  = rdata_q;
    assign cs_n     = cs_n_q;
    assign oe_n     = oe_n_q;
    assign we_n     = we_n_q;
    assign rd_wr    = rd_wr_q;
    assign ebi_addr = ebi_addr_q;
    assign data_o   = data_o_q;
    assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_ebi_master.sv
// tb/tb_ebi_master.sv - self-checking bench for ebi_master
module tb_ebi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0, wr_i = 1'b0;
    logic [21:0] addr_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0, data_i = '0;
    logic        ta_n = 1'b0;
    logic        busy_o, ack_o, err_o, cs_n, oe_n, rd_wr, data_oe;
    logic [31:0] rdata_o, data_o;
    logic [3:0]  we_n;
    logic [23:0] ebi_addr;

    ebi_master #(.SETUP_CYCLES(1), .WAIT_CYCLES(2), .HOLD_CYCLES(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i), .be_i(be_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
        .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n), .rd_wr(rd_wr), .ebi_addr(ebi_addr),
        .data_o(data_o), .data_oe(data_oe), .data_i(data_i), .ta_n(ta_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] ebi;
        int          cs;
        int          strb;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  we;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [21:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdv;
        logic [23:0] ebi;
        int          cs;
        int          strb;
        int          lat;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[6];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rd = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_oe_n"}, oe_n, 1);
        chk({tag, "_we_n"}, we_n, 4'hF);
        chk({tag, "_rd_wr"}, rd_wr, 1);
        chk({tag, "_data_oe"}, data_oe, 0);
        chk({tag, "_ebi_addr"}, ebi_addr, 0);
        chk({tag, "_data_o"}, data_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_ack"}, ack_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
    endtask

    // ta_mode: <0 ta_n low throughout, 0 high throughout, n>0 high until strobe cycle n.
    task automatic txn(input string tag, input logic wr, input logic [21:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] rdv, input int ta_mode, input exp_t e);
        int   cs_cnt = 0, st_cnt = 0, busy_cnt = 0, lat = 0;
        bit   bad_addr = 0, bad_rw = 0, bad_dat = 0, bad_we = 0;
        exp_t got;
        ta_n = (ta_mode < 0) ? 1'b0 : 1'b1;
        repeat (3) @(negedge clk);
        sbq.push_back(e);
        req_i = 1'b1; wr_i = wr; addr_i = addr; be_i = be; wdata_i = wd; data_i = rdv;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) req_i = 1'b0;
            if (!cs_n) begin
                cs_cnt++;
                if (ebi_addr !== e.ebi) bad_addr = 1;
                if (rd_wr !== ~wr) bad_rw = 1;
                if (data_oe !== wr || (wr && data_o !== wd)) bad_dat = 1;
            end
            if (we_n !== 4'hF || !oe_n) begin
                st_cnt++;
                if (wr ? (we_n !== e.we || !oe_n) : (oe_n || we_n !== 4'hF)) bad_we = 1;
                if (ta_mode > 0 && st_cnt == ta_mode) ta_n = 1'b0;
            end
            if (busy_o) busy_cnt++;
            if (ack_o) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_ack_seen"}, (lat != 0), 1);
        got = sbq.pop_front();
        chk({tag, "_ack_latency"}, lat, got.lat);
        chk({tag, "_cs_cycles"}, cs_cnt, got.cs);
        chk({tag, "_strobe_cycles"}, st_cnt, got.strb);
        chk({tag, "_rdata"}, rdata_o, got.rdata);
        chk({tag, "_err"}, err_o, got.err);
        chk({tag, "_busy_at_ack"}, busy_o, 0);
        chk({tag, "_busy_cycles"}, busy_cnt, got.lat - 1);
        chk({tag, "_bus_stable"}, {bad_addr, bad_rw, bad_dat, bad_we}, 0);
        @(negedge clk);
        chk({tag, "_ack_pulse"}, ack_o, 0);
        ta_n = 1'b0;
    endtask

    initial begin
        exp_t        e;
        int          rise, fall2, acks, ack1, ack2, lat;
        logic        prev_cs;

        tbl[0] = '{1'b1, 22'h000123, 4'hC, 32'hDEADBEEF, 32'h0,        24'h00048C, 5, 3, 6};
        tbl[1] = '{1'b0, 22'h3FFFFF, 4'h0, 32'h0,        32'h12345678, 24'hFFFFFC, 5, 3, 6};
        tbl[2] = '{1'b1, 22'h2AAAAA, 4'hF, 32'h0F0F00FF, 32'h0,        24'hAAAAA8, 5, 3, 6};
        tbl[3] = '{1'b1, 22'h000010, 4'h0, 32'h55AA55AA, 32'h0,        24'h000040, 0, 0, 2};
        tbl[4] = '{1'b0, 22'h000000, 4'hF, 32'h0,        32'hA5A5A5A5, 24'h000000, 5, 3, 6};
        tbl[5] = '{1'b1, 22'h155555, 4'h1, 32'h13579BDF, 32'h0,        24'h555554, 5, 3, 6};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            e.ebi   = tbl[i].ebi;
            e.cs    = tbl[i].cs;
            e.strb  = tbl[i].strb;
            e.lat   = tbl[i].lat;
            e.rdata = tbl[i].wr ? last_rd : tbl[i].rdv;
            e.err   = 1'b0;
            e.we    = tbl[i].wr ? ~tbl[i].be : 4'hF;
            txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd, tbl[i].rdv, -1, e);
            if (!tbl[i].wr) last_rd = tbl[i].rdv;
        end

        // Back-to-back reads with req_i held high across DONE.
        repeat (2) @(negedge clk);
        req_i = 1'b1; wr_i = 1'b0; addr_i = 22'h000777; data_i = 32'h0BADF00D;
        rise = 0; fall2 = 0; acks = 0; ack1 = 0; ack2 = 0; prev_cs = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (acks == 1 && k == ack1 + 1) req_i = 1'b0;
            if (!prev_cs && cs_n && rise == 0) rise = k;
            if (prev_cs && !cs_n && rise != 0 && fall2 == 0) fall2 = k;
            prev_cs = cs_n;
            if (ack_o) begin
                acks++;
                if (acks == 1) ack1 = k;
                else ack2 = k;
            end
            if (acks == 2) break;
        end
        req_i = 1'b0;
        chk("b2b_acks", acks, 2);
        chk("b2b_first_rise", rise, 6);
        chk("b2b_cs_high_gap", fall2 - rise, 1);
        chk("b2b_second_ack", ack2 - ack1, 6);
        chk("b2b_rdata", rdata_o, 32'h0BADF00D);

        // Reset pulsed in the middle of a write strobe.
        repeat (2) @(negedge clk);
        req_i = 1'b1; wr_i = 1'b1; addr_i = 22'h0000AA; be_i = 4'hF; wdata_i = 32'h11112222;
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        chk("midrst_pre_strobe", we_n, 4'h0);
        rst = 1'b1;
        #1;
        chk_idle("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_i = 1'b1; wr_i = 1'b0; addr_i = 22'h0000BB; data_i = 32'hCAFEF00D;
        @(negedge clk);
        req_i = 1'b0;
        chk("post_rst_first_accept", cs_n, 0);
        lat = 0;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            if (ack_o) begin
                lat = k;
                break;
            end
        end
        chk("post_rst_latency", lat, 6);
        chk("post_rst_rdata", rdata_o, 32'hCAFEF00D);
        chk("post_rst_err", err_o, 0);
        last_rd = 32'hCAFEF00D;

`ifdef EBI_MASTER_TA_EN
        e = '{24'h000108, 10, 8, 11, last_rd, 1'b1, 4'hF};
        txn("ta_timeout", 1'b0, 22'h000042, 4'hF, 32'h0, 32'h77778888, 0, e);
        e = '{24'h00010C, 9, 7, 10, 32'h99990000, 1'b0, 4'hF};
        txn("ta_ack", 1'b0, 22'h000043, 4'hF, 32'h0, 32'h99990000, 5, e);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
